// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin shared-adder arbiter.
package adder_arb_pkg;

    // Sequencing FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    // Width of a requester index; never narrower than one bit
    function automatic int calc_id_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches upward from last_grant+1,
// wrapping to 0, and returns the first requester found.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    input  logic               i_en,
    output logic               o_any,
    output logic [ID_W-1:0]    o_winner,
    output logic [NUM_REQ-1:0] o_grant
);

    int w_best;
    int w_dist;

    // Pick the active requester with the smallest distance past last_grant
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_best   = NUM_REQ;
        w_dist   = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = j - int'(i_last) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (i_en && i_req[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_winner = ID_W'(j);
                o_any    = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign o_grant[gi] = o_any && (o_winner == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one WIDTH-bit adder among NUM_REQ requesters: round-robin grant,
// operand capture, one registered add cycle, then hold until accepted.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_carry,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [ID_W-1:0]    r_last;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [ID_W-1:0]    r_op_id;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [ID_W-1:0]    r_rsp_id;

    logic               w_any;
    logic [ID_W-1:0]    w_winner;
    logic [NUM_REQ-1:0] w_grant;
    logic [WIDTH-1:0]   w_a [NUM_REQ];
    logic [WIDTH-1:0]   w_b [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign w_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req    (req_valid),
        .i_last   (r_last),
        .i_en     (en),
        .o_any    (w_any),
        .o_winner (w_winner),
        .o_grant  (w_grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: grant -> one add cycle -> hold until consumer accepts
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs: grant only while idle and not being reset; never depends on rsp_ready
    always_comb begin
        req_ready = '0;
        if ((r_state == IDLE) && !rst) begin
            req_ready = w_grant;
        end
        rsp_valid = (r_state == RESP);
        busy      = (r_state != IDLE);
    end

    // Operand capture, round-robin pointer and registered add
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= ID_W'(NUM_REQ - 1);
            r_a      <= '0;
            r_b      <= '0;
            r_op_id  <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_rsp_id <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= w_a[w_winner];
                        r_b     <= w_b[w_winner];
                        r_op_id <= w_winner;
                        r_last  <= w_winner;
                    end
                end
                EXEC: begin
                    {r_carry, r_sum} <= {1'b0, r_a} + {1'b0, r_b};
                    r_rsp_id         <= r_op_id;
                end
                default: ;
            endcase
        end
    end

    assign rsp_sum   = r_sum;
    assign rsp_carry = r_carry;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_adder_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;
    logic [1:0]     rsp_id;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [N-1:0] oh;
        oh = 4'b0001 << v.id;
        en = 1'b1;
        rsp_ready = 1'b1;
        req_a = $urandom;
        req_b = $urandom;
        req_a[v.id*W +: W] = v.a;
        req_b[v.id*W +: W] = v.b;
        req_valid = oh;
        #2;
        chk("vec_grant", 32'(req_ready), 32'(oh));
        cyc();
        req_valid = '0;
        #2;
        chk("vec_exec_valid", 32'(rsp_valid), 32'd0);
        cyc();
        #2;
        chk("vec_valid", 32'(rsp_valid), 32'd1);
        chk("vec_sum", 32'(rsp_sum), 32'(v.sum));
        chk("vec_carry", 32'(rsp_carry), 32'(v.carry));
        chk("vec_id", 32'(rsp_id), 32'(v.id));
        cyc();
        #2;
        chk("vec_idle_busy", 32'(busy), 32'd0);
        cyc();
    endtask

    // Behavioural model state for the randomized run
    int         m_last;
    bit         m_live;
    int         m_age;
    logic [7:0] m_a;
    logic [7:0] m_b;
    int         m_id;
    int         p_win;
    bit         p_acc;
    logic [7:0] p_a;
    logic [7:0] p_b;
    int         m_j;
    int         m_s;
    logic [N-1:0] exp_ready;
    logic         exp_valid;
    logic [N-1:0] oh_t;

    initial begin
        vecs[0] = '{2, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[1] = '{0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{3, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{1, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[4] = '{2, 8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[5] = '{1, 8'h00, 8'h00, 8'h00, 1'b0};

        // Reset with all requesters valid
        rst = 1'b1; en = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
        req_a = '0; req_b = '0;
        req_a[0 +: W] = 8'h05; req_b[0 +: W] = 8'h06;
        cyc(); cyc();
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(rsp_sum), 32'd0);
        chk("rst_carry", 32'(rsp_carry), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        cyc();
        rst = 1'b0;
        #2;
        chk("first_grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        cyc();
        rsp_ready = 1'b1;
        #2;
        chk("first_valid", 32'(rsp_valid), 32'd1);
        chk("first_sum", 32'(rsp_sum), 32'h0B);
        chk("first_id", 32'(rsp_id), 32'd0);
        cyc();
        #2;
        chk("first_idle", 32'(busy), 32'd0);
        cyc();

        // Vector table: single requester ops including wrap-around
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Round robin with all requesters valid
        reset_dut();
        en = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 8'(8'h10 * (i + 1));
            req_b[i*W +: W] = 8'h01;
        end
        for (int k = 0; k < 8; k++) begin
            oh_t = 4'b0001 << (k % N);
            #2;
            chk("rr_grant", 32'(req_ready), 32'(oh_t));
            cyc();
            #2;
            chk("rr_exec_ready", 32'(req_ready), 32'd0);
            cyc();
            #2;
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(k % N));
            chk("rr_sum", 32'(rsp_sum), 32'(8'h10 * ((k % N) + 1) + 1));
            cyc();
        end
        req_valid = '0;
        cyc();

        // Backpressure: hold result for 5 cycles with requester 1 still valid
        req_valid = 4'b0010; rsp_ready = 1'b0;
        req_a[1*W +: W] = 8'h21; req_b[1*W +: W] = 8'h43;
        #2;
        chk("bp_grant", 32'(req_ready), 32'h2);
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_sum", 32'(rsp_sum), 32'h64);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        #2;
        chk("bp_accept_ready", 32'(req_ready), 32'd0);
        cyc();
        #2;
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        cyc();
        #2;
        chk("bp_second_valid", 32'(rsp_valid), 32'd1);
        cyc();
        cyc();

        // en falling during EXEC
        en = 1'b1; req_valid = 4'b0100;
        req_a[2*W +: W] = 8'h0A; req_b[2*W +: W] = 8'h0B;
        #2;
        chk("en_grant", 32'(req_ready), 32'h4);
        cyc();
        en = 1'b0; req_valid = 4'hF;
        #2;
        chk("en_exec_ready", 32'(req_ready), 32'd0);
        chk("en_exec_busy", 32'(busy), 32'd1);
        cyc();
        #2;
        chk("en_valid", 32'(rsp_valid), 32'd1);
        chk("en_sum", 32'(rsp_sum), 32'h15);
        chk("en_id", 32'(rsp_id), 32'd2);
        cyc();
        #2;
        chk("en_off_ready", 32'(req_ready), 32'd0);
        chk("en_off_busy", 32'(busy), 32'd0);
        cyc();
        #2;
        chk("en_off_ready2", 32'(req_ready), 32'd0);
        cyc();
        en = 1'b1;
        #2;
        chk("en_on_grant", 32'(req_ready), 32'h8);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        cyc();

        // Reset during RESP drops the result
        req_valid = 4'b0001; rsp_ready = 1'b0;
        req_a[0 +: W] = 8'h33; req_b[0 +: W] = 8'h44;
        #2;
        chk("rr_rst_grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        cyc();
        #2;
        chk("rr_rst_valid_before", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(rsp_sum), 32'd0);
        cyc();
        #2;
        chk("midrst_stale", 32'(rsp_valid), 32'd0);
        cyc();

        // Randomized run against the behavioural model
        reset_dut();
        m_last = N - 1; m_live = 1'b0; m_age = 0; p_win = -1; p_acc = 1'b0;
        m_a = '0; m_b = '0; m_id = 0; p_a = '0; p_b = '0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) begin
                cyc();
                if (p_win >= 0) begin
                    m_live = 1'b1; m_age = 1;
                    m_a = p_a; m_b = p_b; m_id = p_win; m_last = p_win;
                end else if (m_live) begin
                    if (p_acc) m_live = 1'b0;
                    else m_age++;
                end
            end
            en        = ($urandom_range(0, 7) != 0);
            req_valid = 4'($urandom);
            rsp_ready = 1'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            #2;
            p_win = -1;
            exp_ready = '0;
            if (!m_live && en) begin
                for (int k = 1; k <= N; k++) begin
                    m_j = (m_last + k) % N;
                    if (req_valid[m_j] && p_win < 0) p_win = m_j;
                end
            end
            if (p_win >= 0) begin
                exp_ready[p_win] = 1'b1;
                p_a = req_a[p_win*W +: W];
                p_b = req_b[p_win*W +: W];
            end
            exp_valid = m_live && (m_age >= 2);
            p_acc = exp_valid && rsp_ready;
            chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_valid", 32'(rsp_valid), 32'(exp_valid));
            chk("rnd_busy", 32'(busy), 32'(m_live));
            if (exp_valid) begin
                m_s = int'(m_a) + int'(m_b);
                chk("rnd_sum", 32'(rsp_sum), 32'(m_s % 256));
                chk("rnd_carry", 32'(rsp_carry), 32'(m_s / 256));
                chk("rnd_id", 32'(rsp_id), 32'(m_id));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
